// File: rtl/dsi_power_seq.sv
// dsi_power_seq
// Panel power-up sequencer. After the power-on reset is released it waits for
// en, then runs the panel bring-up in order: a panel reset pulse, a settle
// delay, LP-11 idle on the link, and the init-command handshake with the
// command sender. It then holds ready so the video path may start.
// If the command sender does not answer within T_INIT_TO cycles, the block
// parks in FAULT until en is dropped or reset is applied.
//
// One shared delay counter times every timed state. It clears when a state is
// entered and the state is left on the cycle where cnt == T_x - 1, so each
// timed state lasts exactly T_x cycles. Dropping en aborts from any state, and
// the next enable always replays the whole sequence.
module dsi_power_seq #(
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned T_RST_LOW  = 1000,
  parameter int unsigned T_RST_WAIT = 120000,
  parameter int unsigned T_LP11     = 2000,
  parameter int unsigned T_INIT_TO  = 2000000
) (
  input  logic clk,
  input  logic rst,          // synchronous, active-low
  input  logic en,
  input  logic init_done,
  output logic panel_rst_n,
  output logic lp11_en,
  output logic init_req,
  output logic ready,
  output logic fault
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  localparam longint unsigned CNT_MAX  = (64'd1 << CNT_W) - 64'd1;
  localparam longint unsigned LAST_MAX =
    (longint'(T_INIT_TO)  > longint'(T_RST_WAIT)) ?
      ((longint'(T_INIT_TO) > longint'(T_LP11)) ?
         longint'(T_INIT_TO) : longint'(T_LP11)) :
      ((longint'(T_RST_WAIT) > longint'(T_LP11)) ?
         longint'(T_RST_WAIT) : longint'(T_LP11));
  localparam longint unsigned T_MAX =
    (LAST_MAX > longint'(T_RST_LOW)) ? LAST_MAX : longint'(T_RST_LOW);

  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("dsi_power_seq: CNT_W must be between 1 and 32");
  end

  if (T_RST_LOW < 1 || T_RST_WAIT < 1 || T_LP11 < 1 || T_INIT_TO < 1)
  begin : g_bad_delay
    $error("dsi_power_seq: every T_x delay must be at least 1 cycle");
  end

  // The counter must reach T_x - 1 without wrapping for every timed state.
  if ((T_MAX - 64'd1) > CNT_MAX) begin : g_cnt_too_narrow
    $error("dsi_power_seq: CNT_W too narrow for the largest T_x - 1");
  end

  // --------------------------------------------------------------------------
  // Terminal counts, one per timed state
  // --------------------------------------------------------------------------
  localparam logic [CNT_W-1:0] LAST_RST_LOW  = CNT_W'(T_RST_LOW  - 1);
  localparam logic [CNT_W-1:0] LAST_RST_WAIT = CNT_W'(T_RST_WAIT - 1);
  localparam logic [CNT_W-1:0] LAST_LP11     = CNT_W'(T_LP11     - 1);
  localparam logic [CNT_W-1:0] LAST_INIT     = CNT_W'(T_INIT_TO  - 1);

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRST_LOW  = 3'd1,
    S_PRST_WAIT = 3'd2,
    S_LP11      = 3'd3,
    S_INIT      = 3'd4,
    S_RUN       = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  // Output pin values for one state, bundled so that they can be registered
  // together.
  typedef struct packed {
    logic panel_rst_n;
    logic lp11_en;
    logic init_req;
    logic ready;
    logic fault;
  } pins_t;

  localparam pins_t PINS_RESET = '0;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  pins_t            pins_q, pins_nx;

  // Pin levels implied by a state. The panel is out of reset from PRST_WAIT
  // onward, and it stays out of reset in FAULT so that it can be inspected.
  // FAULT releases the link, so LP-11 is not driven in that state.
  function automatic pins_t decode_pins(input state_t s);
    pins_t p;
    p             = PINS_RESET;
    p.panel_rst_n = (s == S_PRST_WAIT) || (s == S_LP11) || (s == S_INIT) ||
                    (s == S_RUN)       || (s == S_FAULT);
    p.lp11_en     = (s == S_LP11) || (s == S_INIT) || (s == S_RUN);
    p.init_req    = (s == S_INIT);
    p.ready       = (s == S_RUN);
    p.fault       = (s == S_FAULT);
    return p;
  endfunction

  // Next-state and counter logic. The transition table applies first, and a
  // low en then overrides every state except IDLE.
  always_comb begin
    // NOTE: default every always_comb output before the case statement so that
    // no path leaves a value unassigned; an unassigned path infers a latch.
    state_nx = state;
    cnt_nx   = cnt + 1'b1;

    unique case (state)
      S_IDLE: begin
        if (en) state_nx = S_PRST_LOW;
      end
      S_PRST_LOW: begin
        if (cnt == LAST_RST_LOW) state_nx = S_PRST_WAIT;
      end
      S_PRST_WAIT: begin
        if (cnt == LAST_RST_WAIT) state_nx = S_LP11;
      end
      S_LP11: begin
        if (cnt == LAST_LP11) state_nx = S_INIT;
      end
      S_INIT: begin
        // If init_done and the timeout fall on the same cycle, init_done wins.
        if (init_done)              state_nx = S_RUN;
        else if (cnt == LAST_INIT)  state_nx = S_FAULT;
      end
      S_RUN:   state_nx = S_RUN;
      S_FAULT: state_nx = S_FAULT;
      default: state_nx = S_IDLE;
    endcase

    if (!en && state != S_IDLE) state_nx = S_IDLE;

    // The counter restarts on every state entry. It rests at zero in the
    // untimed states, so it can never wrap while the block sits in RUN or
    // FAULT.
    if (state_nx != state || state_nx == S_IDLE ||
        state_nx == S_RUN  || state_nx == S_FAULT) begin
      cnt_nx = '0;
    end

    pins_nx = decode_pins(state_nx);
  end

  // State, counter and output registers. The outputs are registered from the
  // next-state decode, so they always match the current state with no
  // glitches.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples values from before the clock edge.
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      pins_q <= PINS_RESET;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      pins_q <= pins_nx;
    end
  end

  assign panel_rst_n = pins_q.panel_rst_n;
  assign lp11_en     = pins_q.lp11_en;
  assign init_req    = pins_q.init_req;
  assign ready       = pins_q.ready;
  assign fault       = pins_q.fault;

endmodule

// File: tb/tb_dsi_power_seq.sv
// tb_dsi_power_seq
// Directed and random stimulus for dsi_power_seq, run with short delays.
// The reference model tracks the age of the current bring-up (the number of
// cycles since PRST_LOW was entered) and whether init_done arrived during the
// INIT window. It derives the expected pin levels from that age and the phase
// boundaries.
module tb_dsi_power_seq;

  localparam int unsigned CNT_W      = 8;
  localparam int unsigned T_RST_LOW  = 4;
  localparam int unsigned T_RST_WAIT = 5;
  localparam int unsigned T_LP11     = 6;
  localparam int unsigned T_INIT_TO  = 20;

  // Age at which each phase begins. Age 1 is the first PRST_LOW cycle.
  localparam int A_WAIT  = T_RST_LOW + 1;
  localparam int A_LP11  = A_WAIT + T_RST_WAIT;
  localparam int A_INIT  = A_LP11 + T_LP11;
  localparam int A_FAULT = A_INIT + T_INIT_TO;

  logic clk = 1'b0;
  logic rst, en, init_done;
  logic panel_rst_n, lp11_en, init_req, ready, fault;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_active = 1'b0;
  int m_age    = 0;
  bit m_done   = 1'b0;

  dsi_power_seq #(
    .CNT_W      (CNT_W),
    .T_RST_LOW  (T_RST_LOW),
    .T_RST_WAIT (T_RST_WAIT),
    .T_LP11     (T_LP11),
    .T_INIT_TO  (T_INIT_TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .init_done   (init_done),
    .panel_rst_n (panel_rst_n),
    .lp11_en     (lp11_en),
    .init_req    (init_req),
    .ready       (ready),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Moves the model forward by one clock edge, using the inputs sampled at
  // that edge.
  task automatic model_step(input bit r, input bit e, input bit d);
    if (!r) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (e) begin
        m_active = 1'b1;
        m_age    = 1;
        m_done   = 1'b0;
      end
    end else if (!e) begin
      m_active = 1'b0;
    end else begin
      if (!m_done && d && m_age >= A_INIT && m_age < A_FAULT) m_done = 1'b1;
      if (m_age < 100000) m_age++;
    end
  endtask

  task automatic check_outputs(input string tag);
    bit e_prn, e_lp, e_req, e_rdy, e_flt;
    {e_prn, e_lp, e_req, e_rdy, e_flt} = 5'b0;
    if (m_active) begin
      if (m_done) begin
        {e_prn, e_lp, e_rdy} = 3'b111;
      end else if (m_age >= A_FAULT) begin
        {e_prn, e_flt} = 2'b11;
      end else if (m_age >= A_INIT) begin
        {e_prn, e_lp, e_req} = 3'b111;
      end else if (m_age >= A_LP11) begin
        {e_prn, e_lp} = 2'b11;
      end else if (m_age >= A_WAIT) begin
        e_prn = 1'b1;
      end
    end
    check({tag, ".panel_rst_n"}, 32'(panel_rst_n), 32'(e_prn));
    check({tag, ".lp11_en"},     32'(lp11_en),     32'(e_lp));
    check({tag, ".init_req"},    32'(init_req),    32'(e_req));
    check({tag, ".ready"},       32'(ready),       32'(e_rdy));
    check({tag, ".fault"},       32'(fault),       32'(e_flt));
  endtask

  // Runs one clock cycle: drive the inputs, take the edge, update the model,
  // then compare the outputs 1 time unit after the edge.
  task automatic cyc(input string tag, input bit r, input bit e, input bit d);
    rst       = r;
    en        = e;
    init_done = d;
    @(posedge clk);
    model_step(r, e, d);
    #1;
    check_outputs(tag);
  endtask

  // Runs n cycles with rst high. init_done pulses on the cycle where the
  // model age equals da or db; pass -1 to disable a pulse.
  task automatic run(input string tag, input int n, input bit e,
                     input int da, input int db);
    for (int i = 0; i < n; i++) begin
      bit d;
      d = m_active && (m_age == da || m_age == db);
      cyc(tag, 1'b1, e, d);
    end
  endtask

  initial begin
    int n;

    // 1: reset for 3 cycles, then stay idle with en low.
    for (int i = 0; i < 3; i++) cyc("reset", 1'b0, 1'b0, 1'b0);
    run("idle", 10, 1'b0, -1, -1);

    // 2: normal bring-up with init_done on the third INIT cycle, and a
    //    measurement of the latency from en rising to ready rising.
    n = 0;
    do begin
      cyc("bringup", 1'b1, 1'b1,
          m_active && !m_done && m_age == A_INIT + 2);
      n++;
    end while (ready !== 1'b1 && n < 100);
    check("latency", 32'(n), 32'(1 + T_RST_LOW + T_RST_WAIT + T_LP11 + 3));
    run("run_hold", 5, 1'b1, -1, -1);

    // 3: no init_done, so the block times out into FAULT; en low then clears
    //    it.
    run("abort1", 2, 1'b0, -1, -1);
    run("timeout", A_FAULT + 5, 1'b1, -1, -1);
    check("fault_set", 32'(fault), 32'd1);
    run("fault_clr", 3, 1'b0, -1, -1);
    check("fault_clr_pin", 32'(fault), 32'd0);

    // 4: an init_done during LP11 is ignored, and an init_done on the last
    //    INIT cycle wins over the timeout.
    run("last_cycle", A_FAULT + 5, 1'b1, A_LP11 + 2, A_FAULT - 1);
    check("last_cycle_ready", 32'(ready), 32'd1);
    run("abort2", 2, 1'b0, -1, -1);

    // 5: abort in the middle of PRST_WAIT, then re-enable for a full replay.
    run("prst_wait", A_WAIT + 2, 1'b1, -1, -1);
    run("abort3", 2, 1'b0, -1, -1);
    run("replay", A_INIT + 4, 1'b1, A_INIT + 1, -1);

    // 6: reset while in RUN, then restart from PRST_LOW.
    check("pre_rst_ready", 32'(ready), 32'd1);
    cyc("rst_in_run", 1'b0, 1'b1, 1'b0);
    run("restart", A_INIT + 6, 1'b1, A_INIT + 3, -1);

    // Random: en toggles occasionally, init_done pulses often, and a rare
    // reset is applied.
    en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      bit r, e, d;
      r = ($urandom_range(0, 299) != 0);
      e = ($urandom_range(0, 59) == 0) ? ~en : en;
      d = ($urandom_range(0, 29) == 0);
      cyc("random", r, e, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
